// File: rtl/counter_sequencer_pkg.sv
// Shared opcode and state encodings for the counter sequencer.
package counter_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_HOLD     = 3'd1,
    OP_PRESET   = 3'd2,
    OP_SET_LO   = 3'd3,
    OP_SET_HI   = 3'd4,
    OP_RUN_UP   = 3'd5,
    OP_RUN_DOWN = 3'd6,
    OP_PINGPONG = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_PRESET  = 3'd1,
    ST_UP      = 3'd2,
    ST_DOWN    = 3'd3,
    ST_PP_UP   = 3'd4,
    ST_PP_DOWN = 3'd5
  } state_e;

  function automatic logic is_busy(state_e s);
    return (s == ST_UP) || (s == ST_DOWN) || (s == ST_PP_UP) || (s == ST_PP_DOWN);
  endfunction

endpackage

// File: rtl/counter_sequencer_if.sv
// Host command handshake plus the control/feedback bundle to the downstream counter.
interface counter_sequencer_if #(
  parameter int WIDTH = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] cnt_in;
  logic             load;
  logic             upDown;
  logic [WIDTH-1:0] loadValue;
  logic             busy;
  logic             limit_hit;
  logic             cmd_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cnt_in,
    input  cmd_ready, load, upDown, loadValue, busy, limit_hit, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cnt_in,
    output cmd_ready, load, upDown, loadValue, busy, limit_hit, cmd_err
  );
endinterface

// File: rtl/counter_sequencer_limits.sv
// Programmable lo/hi limit registers with write validation and count-vs-limit flags.
module counter_sequencer_limits #(
  parameter int WIDTH      = 4,
  parameter int DEFAULT_LO = 0,
  parameter int DEFAULT_HI = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_lo_i,
  input  logic             set_hi_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] cnt_i,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             reject_o,
  output logic             equal_o,
  output logic             below_hi_o,
  output logic             above_lo_o
);
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;

  // A write that would leave lo above hi is refused and the limit keeps its value.
  always_comb begin
    lo_d     = lo_q;
    hi_d     = hi_q;
    reject_o = 1'b0;
    if (set_lo_i) begin
      if (data_i > hi_q) reject_o = 1'b1;
      else               lo_d     = data_i;
    end else if (set_hi_i) begin
      if (data_i < lo_q) reject_o = 1'b1;
      else               hi_d     = data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_q <= WIDTH'(DEFAULT_LO);
      hi_q <= WIDTH'(DEFAULT_HI);
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign lo_o       = lo_q;
  assign hi_o       = hi_q;
  assign equal_o    = (lo_q == hi_q);
  assign below_hi_o = (cnt_i < hi_q);
  assign above_lo_o = (cnt_i > lo_q);
endmodule

// File: rtl/counter_sequencer.sv
// Command-driven controller for a registered up/down counter: hold, preset,
// bounded runs and ping-pong sweeps between programmable limits.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DEFAULT_LO = 0,
  parameter int DEFAULT_HI = 15
) (
  input  logic               clk,
  input  logic               reset,
  counter_sequencer_if.slave bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] pre_q, pre_d;
  logic             limit_hit_q, limit_hit_d;
  logic             cmd_err_q, cmd_err_d;

  logic             accept;
  op_e              op;
  logic             set_lo, set_hi;
  logic [WIDTH-1:0] lo, hi;
  logic             reject, equal, below_hi, above_lo;
  logic             load_c, up_down_c;
  logic [WIDTH-1:0] load_value_c;

  assign op     = op_e'(bus.cmd_op);
  assign accept = bus.cmd_valid & bus.cmd_ready;
  assign set_lo = accept && (op == OP_SET_LO);
  assign set_hi = accept && (op == OP_SET_HI);

  counter_sequencer_limits #(
    .WIDTH      (WIDTH),
    .DEFAULT_LO (DEFAULT_LO),
    .DEFAULT_HI (DEFAULT_HI)
  ) u_limits (
    .clk        (clk),
    .reset      (reset),
    .set_lo_i   (set_lo),
    .set_hi_i   (set_hi),
    .data_i     (bus.cmd_data),
    .cnt_i      (bus.cnt_in),
    .lo_o       (lo),
    .hi_o       (hi),
    .reject_o   (reject),
    .equal_o    (equal),
    .below_hi_o (below_hi),
    .above_lo_o (above_lo)
  );

  always_comb begin
    state_d      = state_q;
    pre_d        = pre_q;
    limit_hit_d  = 1'b0;
    load_c       = 1'b1;
    load_value_c = bus.cnt_in;
    up_down_c    = 1'b0;

    // Mode behaviour; limit decisions use the current count so it never overshoots.
    unique case (state_q)
      ST_HOLD: ;
      ST_PRESET: begin
        load_value_c = pre_q;
        state_d      = ST_HOLD;
      end
      ST_UP: begin
        if (below_hi) begin
          load_c    = 1'b0;
          up_down_c = 1'b1;
        end else begin
          load_value_c = hi;
          limit_hit_d  = 1'b1;
          state_d      = ST_HOLD;
        end
      end
      ST_DOWN: begin
        if (above_lo) begin
          load_c = 1'b0;
        end else begin
          load_value_c = lo;
          limit_hit_d  = 1'b1;
          state_d      = ST_HOLD;
        end
      end
      ST_PP_UP: begin
        load_c    = 1'b0;
        up_down_c = below_hi;
        if (!below_hi) begin
          limit_hit_d = 1'b1;
          state_d     = ST_PP_DOWN;
        end
      end
      ST_PP_DOWN: begin
        load_c    = 1'b0;
        up_down_c = !above_lo;
        if (!above_lo) begin
          limit_hit_d = 1'b1;
          state_d     = ST_PP_UP;
        end
      end
      default: state_d = ST_HOLD;
    endcase

    // An accepted mode command overrides the mode's own transition next cycle.
    if (accept) begin
      unique case (op)
        OP_HOLD:     state_d = ST_HOLD;
        OP_PRESET: begin
          pre_d   = bus.cmd_data;
          state_d = ST_PRESET;
        end
        OP_RUN_UP:   state_d = ST_UP;
        OP_RUN_DOWN: state_d = ST_DOWN;
        OP_PINGPONG: state_d = equal ? ST_HOLD : ST_PP_UP;
        default: ;
      endcase
    end

    cmd_err_d = reject | (accept && (op == OP_PINGPONG) && equal);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_HOLD;
      pre_q       <= '0;
      limit_hit_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      limit_hit_q <= limit_hit_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign bus.cmd_ready = (state_q != ST_PRESET);
  assign bus.load      = load_c;
  assign bus.upDown    = up_down_c;
  assign bus.loadValue = load_value_c;
  assign bus.busy      = is_busy(state_q);
  assign bus.limit_hit = limit_hit_q;
  assign bus.cmd_err   = cmd_err_q;
endmodule
